// File: rtl/uart_pkg.sv
// Shared definitions for the 8N1 serial link (receiver and transmitter).
package uart_pkg;

    localparam int unsigned UART_DATA_BITS = 8;
    localparam int unsigned UART_STOP_BITS = 1;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT_HIGH
    } uart_rx_state_t;

endpackage

// File: rtl/uart_rx_8n1_if.sv
// Byte-stream side of the 8N1 receiver: one-entry buffer handshake plus error pulses.
interface uart_rx_8n1_if;

    logic [7:0] rxbyte;
    logic       rxvalid;
    logic       rxready;
    logic       framing_err;
    logic       overrun;

    modport master (
        output rxbyte,
        output rxvalid,
        output framing_err,
        output overrun,
        input  rxready
    );

    modport slave (
        input  rxbyte,
        input  rxvalid,
        input  framing_err,
        input  overrun,
        output rxready
    );

endinterface

// File: rtl/uart_rx_8n1_sync2.sv
// Two-flop synchroniser; both flops reset to RESET_VAL.
module sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic s1;

    // Shift the asynchronous input through two flops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1 <= RESET_VAL;
            q  <= RESET_VAL;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

endmodule

// File: rtl/uart_rx_8n1.sv
// 8N1 serial receiver with a one-entry valid/ready output buffer,
// framing-error and overrun pulses.
module uart_rx_8n1
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          rx,
    uart_rx_8n1_if.master rx_if
);

    localparam int unsigned HALF = (CLKS_PER_BIT - 1) / 2;
    localparam int unsigned CW   = $clog2(CLKS_PER_BIT) + 1;
    localparam int unsigned IW   = $clog2(UART_DATA_BITS);

    localparam logic [CW-1:0] CNT_HALF = CW'(HALF);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(UART_DATA_BITS - 1);

    logic                      s2;
    uart_rx_state_t            state_q, state_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic [IW-1:0]             idx_q, idx_d;
    logic [UART_DATA_BITS-1:0] shreg_q, shreg_d;
    logic [7:0]                rxbyte_q, rxbyte_d;
    logic                      rxvalid_q, rxvalid_d;
    logic                      ferr_q, ferr_d;
    logic                      ovr_q, ovr_d;
    logic                      deliver;
    logic                      frame_bad;

    sync2 #(.RESET_VAL(1'b1)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx),
        .q     (s2)
    );

    // State, bit timer, bit index and shift register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
        end
    end

    // Frame sequencing: start-bit check, data sampling, stop-bit check.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        shreg_d   = shreg_q;
        deliver   = 1'b0;
        frame_bad = 1'b0;
        case (state_q)
            RX_IDLE: begin
                if (!s2) begin
                    if (HALF == 0) begin
                        state_d = RX_DATA;
                        cnt_d   = '0;
                        idx_d   = '0;
                    end else begin
                        // The edge that sees the falling start bit is already
                        // the first of the half-bit wait, so count from 1.
                        state_d = RX_START;
                        cnt_d   = CW'(1);
                    end
                end
            end
            RX_START: begin
                if (cnt_q == CNT_HALF) begin
                    if (!s2) begin
                        state_d = RX_DATA;
                        cnt_d   = '0;
                        idx_d   = '0;
                    end else begin
                        state_d = RX_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RX_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    shreg_d[idx_q] = s2;
                    cnt_d          = '0;
                    if (idx_q == IDX_LAST) begin
                        state_d = RX_STOP;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RX_STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (s2) begin
                        state_d = RX_IDLE;
                        deliver = 1'b1;
                    end else begin
                        state_d   = RX_WAIT_HIGH;
                        frame_bad = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RX_WAIT_HIGH: begin
                if (s2) begin
                    state_d = RX_IDLE;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    // Output buffer: drain on handshake, load on delivery (drain and load may coincide).
    always_comb begin
        rxbyte_d  = rxbyte_q;
        rxvalid_d = rxvalid_q;
        ferr_d    = frame_bad;
        ovr_d     = 1'b0;
        if (rxvalid_q && rx_if.rxready) begin
            rxvalid_d = 1'b0;
        end
        if (deliver) begin
            if (!rxvalid_q || rx_if.rxready) begin
                rxbyte_d  = shreg_q;
                rxvalid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    // Registered outputs; no combinational path from rxready to rxvalid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rxbyte_q  <= '0;
            rxvalid_q <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            rxbyte_q  <= rxbyte_d;
            rxvalid_q <= rxvalid_d;
            ferr_q    <= ferr_d;
            ovr_q     <= ovr_d;
        end
    end

    assign rx_if.rxbyte      = rxbyte_q;
    assign rx_if.rxvalid     = rxvalid_q;
    assign rx_if.framing_err = ferr_q;
    assign rx_if.overrun     = ovr_q;

endmodule
